// File: rtl/kernel_pool2d_pkg.sv
// kernel_pool2d_pkg: shared constants and helpers for the streaming pooling engine.
// Holds the default element width, on/off levels, the mode encodings and a
// log2 helper used to size the average accumulator and the beat counter.
package kernel_pool2d_pkg;

  localparam int BIT_DATA_DEFAULT = 16;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // Exact log2 for power-of-two window sizes.
  function automatic int log2_window(input int window);
    int n;
    n = 0;
    while ((1 << n) < window) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/kernel_pool2d_pool_lane.sv
// kernel_pool2d_pool_lane: one channel's accumulator, max/sum update and final shift.
// Latency: result is combinational from the current element and accumulator.
// Backpressure: none here; en is already the qualified handshake from the top.
// Ports: clock, reset_n; en (beat accepted), first/last (window position),
//        mode_q (mode in force for this beat), element (signed input),
//        result (pooled value, meaningful when last && en).
module kernel_pool2d_pool_lane
  import kernel_pool2d_pkg::*;
#(
  parameter int BIT_DATA = 16,
  parameter int LOG2W    = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                en,
  input  logic                first,
  input  logic                last,
  input  logic                mode_q,
  input  logic [BIT_DATA-1:0] element,
  output logic [BIT_DATA-1:0] result
);

  // Extra LOG2W bits let a full window of extreme values sum without wrap.
  localparam int AW = BIT_DATA + LOG2W;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] elem_ext;

  assign elem_ext = AW'($signed(element));

  // First beat loads the element directly, so an all-negative window never
  // competes against the reset value of the accumulator.
  always_comb begin
    acc_next = acc;
    if (first) begin
      acc_next = elem_ext;
    end else if (mode_q == MODE_AVG) begin
      acc_next = acc + elem_ext;
    end else begin
      acc_next = (elem_ext > acc) ? elem_ext : acc;
    end
  end

  // The last beat's combined value goes straight to the output register in
  // the top, so the accumulator need not capture it; the next window reloads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (en && !last) begin
      acc <= acc_next;
    end
  end

  // Arithmetic shift floors toward minus infinity; the mean of in-range
  // values is in range, so dropping the guard bits is lossless.
  assign result = (mode_q == MODE_MAX) ? BIT_DATA'(acc_next)
                                       : BIT_DATA'(acc_next >>> LOG2W);

endmodule

// File: rtl/kernel_pool2d.sv
// kernel_pool2d: streaming max/average pooling over WINDOW serial beats on CHANNELS lanes.
// Latency: result registered one cycle after the last beat's handshake; one window per WINDOW cycles.
// Backpressure: only the last beat of a window stalls, and only while an undrained result is held.
// Ports: clock, reset_n (async active-low); mode (0 max, 1 average, sampled on
//        a window's first beat); flush (sync abort of the partial window);
//        in_valid/in_ready/in_data input stream; out_valid/out_ready/out_data
//        result stream. Lane 0 occupies the LSBs of both data buses.
module kernel_pool2d
  import kernel_pool2d_pkg::*;
#(
  parameter int BIT_DATA = BIT_DATA_DEFAULT,
  parameter int CHANNELS = 4,
  parameter int WINDOW   = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         mode,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BIT_DATA-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*BIT_DATA-1:0] out_data
);

  localparam int LOG2W = log2_window(WINDOW);
  localparam int CW    = LOG2W;
  localparam logic [CW-1:0] LAST_BEAT = CW'(WINDOW - 1);

  logic [CW-1:0]                count;
  logic                         mode_q;
  logic                         first;
  logic                         last;
  logic                         accept;
  logic                         mode_cur;
  logic [CHANNELS*BIT_DATA-1:0] lane_result;

  assign first = (count == '0);
  assign last  = (count == LAST_BEAT);

  // Earlier beats only touch the accumulators, so they never need to wait;
  // the last beat needs the output register free (or draining this cycle).
  assign in_ready = !(last && out_valid && !out_ready);

  // Flush wins over a simultaneous handshake: that beat is dropped.
  assign accept = in_valid && in_ready && !flush;

  // On the first beat the lanes must use the incoming mode, since mode_q
  // only picks it up at the end of this cycle.
  assign mode_cur = first ? mode : mode_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    kernel_pool2d_pool_lane #(
      .BIT_DATA (BIT_DATA),
      .LOG2W    (LOG2W)
    ) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (accept),
      .first   (first),
      .last    (last),
      .mode_q  (mode_cur),
      .element (in_data[g*BIT_DATA +: BIT_DATA]),
      .result  (lane_result[g*BIT_DATA +: BIT_DATA])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (accept) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_MAX;
    end else if (accept && first) begin
      mode_q <= mode;
    end
  end

  // A load in the same cycle as a drain keeps out_valid high; flush leaves
  // the held result alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= OFF;
      out_data  <= '0;
    end else if (accept && last) begin
      out_valid <= ON;
      out_data  <= lane_result;
    end else if (out_ready) begin
      out_valid <= OFF;
    end
  end

endmodule

// File: tb/tb_kernel_pool2d.sv
module tb_kernel_pool2d;

  localparam int BD = 16;
  localparam int CH = 2;
  localparam int WN = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          mode;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CH*BD-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CH*BD-1:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  kernel_pool2d #(.BIT_DATA(BD), .CHANNELS(CH), .WINDOW(WN)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mode      (mode),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] pk(input int a0, input int a1);
    logic [15:0] b0;
    logic [15:0] b1;
    b0 = a0[15:0];
    b1 = a1[15:0];
    return {b1, b0};
  endfunction

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  // Pool a complete window using plain integer arithmetic.
  function automatic int pool(input logic m, input int v[$]);
    int r;
    if (m) begin
      r = 0;
      foreach (v[i]) r = r + v[i];
      r = floor_div(r, v.size());
    end else begin
      r = v[0];
      foreach (v[i]) if (v[i] > r) r = v[i];
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic m, input int a0, input int a1, input logic fl);
    in_valid = 1'b1;
    mode     = m;
    in_data  = pk(a0, a1);
    flush    = fl;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0; mode = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_max_negative;
    int l0[4] = '{3, -7, 12, 5};
    int l1[4] = '{-5, -2, -9, -8};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, l0[i], l1[i], 1'b0);
      #4;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL max_in_ready beat %0d got %b want 1", i, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_early_valid beat %0d got %b want 0", i, out_valid); end
      tick;
    end
    idle;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL max_latency got %b want 1", out_valid); end
    checks++; if (out_data !== pk(12, -2)) begin errors++; $display("FAIL max_value got %h want %h", out_data, pk(12, -2)); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_drain got %b want 0", out_valid); end
  endtask

  task automatic test_average;
    int l0[2][4] = '{'{4, 5, 6, 8}, '{32767, 32767, 32767, 32767}};
    int l1[2][4] = '{'{-1, -2, -2, -2}, '{-32768, -32768, -32768, -32768}};
    logic [31:0] exp_v[2];
    exp_v[0] = pk(5, -2);
    exp_v[1] = pk(32767, -32768);
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        beat(1'b1, l0[c][i], l1[c][i], 1'b0);
        tick;
      end
      idle;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL avg_valid case %0d got %b want 1", c, out_valid); end
      checks++; if (out_data !== exp_v[c]) begin errors++; $display("FAIL avg_value case %0d got %h want %h", c, out_data, exp_v[c]); end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    int v1;
    int got;
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      v0 = (i < 4) ? i * 3 - 4 : 100 - i;
      v1 = -i;
      beat(i >= 4, v0, v1, 1'b0);
      #4;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", i, in_ready); end
      tick;
      if (i == 3) begin
        got++;
        checks++; if (out_data !== pk(5, 0)) begin errors++; $display("FAIL b2b_first got %h want %h", out_data, pk(5, 0)); end
      end
    end
    idle;
    // window 2 average: lane0 (96+95+94+93)/4 = 94.5 -> 94, lane1 -22/4 -> -6
    checks++; if (out_valid !== 1'b1 || out_data !== pk(94, -6)) begin
      errors++; $display("FAIL b2b_second got %b/%h want 1/%h", out_valid, out_data, pk(94, -6));
    end
    tick;
  endtask

  task automatic test_backpressure;
    logic [31:0] res_a;
    logic [31:0] res_b;
    res_a = pk(4, 40);
    res_b = pk(8, 80);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, i + 1, (i + 1) * 10, 1'b0);
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, i + 5, (i + 5) * 10, 1'b0);
      #4;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_mid_ready beat %0d got %b want 1", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== res_a) begin
        errors++; $display("FAIL bp_hold beat %0d got %b/%h want 1/%h", i, out_valid, out_data, res_a);
      end
      tick;
    end
    beat(1'b0, 8, 80, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall cycle %0d got %b want 0", i, in_ready); end
      checks++; if (out_data !== res_a) begin errors++; $display("FAIL bp_stable cycle %0d got %h want %h", i, out_data, res_a); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick;
    idle;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== res_b) begin
      errors++; $display("FAIL bp_second got %b/%h want 1/%h", out_valid, out_data, res_b);
    end
    out_ready = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush;
    logic [31:0] held;
    int n_out;
    held = pk(9, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin beat(1'b0, 9, 1, 1'b0); tick; end
    beat(1'b1, 100, 100, 1'b0); tick;
    beat(1'b1, 100, 100, 1'b0); tick;
    beat(1'b1, 100, 100, 1'b1); tick;
    idle;
    checks++; if (out_valid !== 1'b1 || out_data !== held) begin
      errors++; $display("FAIL flush_held got %b/%h want 1/%h", out_valid, out_data, held);
    end
    out_ready = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain got %b want 0", out_valid); end
    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) beat(1'b0, i + 1, -(i + 1), 1'b0);
      else idle;
      tick;
      if (out_valid === 1'b1) begin
        n_out++;
        checks++; if (out_data !== pk(4, -1)) begin errors++; $display("FAIL flush_value got %h want %h", out_data, pk(4, -1)); end
      end
    end
    idle;
    checks++; if (n_out != 1) begin errors++; $display("FAIL flush_count got %0d want 1", n_out); end
  endtask

  task automatic test_reset_mid;
    int l0[4] = '{1, 2, 3, 10};
    int l1[4] = '{-3, -3, -3, -4};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin beat(1'b0, 7, 7, 1'b0); tick; end
    for (int i = 0; i < 3; i++) begin beat(1'b1, 50, -50, 1'b0); tick; end
    idle;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data got %h want 0", out_data); end
    #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      beat(i == 0, l0[i], l1[i], 1'b0);
      tick;
    end
    idle;
    // average kept despite mode dropping to max after the first beat
    checks++; if (out_valid !== 1'b1 || out_data !== pk(4, -4)) begin
      errors++; $display("FAIL rst_mid_result got %b/%h want 1/%h", out_valid, out_data, pk(4, -4));
    end
    tick;
  endtask

  task automatic test_random;
    int q0[$];
    int q1[$];
    logic mq;
    logic held;
    logic [31:0] hval;
    logic exp_ready;
    int fails_before;
    reset_n = 1'b0;
    idle;
    #3;
    reset_n = 1'b1;
    tick;
    held = 1'b0; hval = '0; mq = 1'b0;
    fails_before = errors;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      mode      = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      #4;
      exp_ready = !(q0.size() == WN - 1 && held && !out_ready);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", cyc, in_ready, exp_ready); end
      checks++; if (out_valid !== held) begin errors++; $display("FAIL rnd_out_valid cycle %0d got %b want %b", cyc, out_valid, held); end
      if (held) begin
        checks++; if (out_data !== hval) begin errors++; $display("FAIL rnd_out_data cycle %0d got %h want %h", cyc, out_data, hval); end
      end
      if (out_ready) held = 1'b0;
      if (flush) begin
        q0.delete();
        q1.delete();
      end else if (in_valid && exp_ready) begin
        if (q0.size() == 0) mq = mode;
        q0.push_back($signed(in_data[15:0]));
        q1.push_back($signed(in_data[31:16]));
        if (q0.size() == WN) begin
          hval = pk(pool(mq, q0), pool(mq, q1));
          held = 1'b1;
          q0.delete();
          q1.delete();
        end
      end
      if (errors - fails_before > 20) break;
      tick;
    end
    idle;
  endtask

  initial begin
    test_reset;
    test_max_negative;
    test_average;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
